// File: rtl/irqctl_pkg.sv
// Shared types and limits for the interrupt controller.
package irqctl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irqctl_state_t;

  localparam int MAX_SRC = 32;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the pending vector.
module irq_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: enable mask, pending latch, lowest-index arbitration
// and a single-outstanding req/ack/eoi handshake to the CPU.
// Optional macro IRQCTL_EDGE_EN switches pending sets from level to rising edge.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | nothing in flight; picks lowest pending source when any
//   REQ     | irq_req high, irq_id frozen until the CPU acks
//   SERVICE | irq_busy high, CPU handling irq_id until eoi
module irq_controller
  import irqctl_pkg::*;
#(
  parameter  int NUM_SRC = 8,
  localparam int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] irq_enable,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               irq_busy
);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
    $error("irq_controller: NUM_SRC out of range 2..32");
  end

  irqctl_state_t      state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic               ack_take;
  logic               enc_any;
  logic [ID_W-1:0]    enc_idx;

`ifdef IRQCTL_EDGE_EN
  logic [NUM_SRC-1:0] irq_in_q;

  // Previous-cycle copy of the lines, used to detect rising edges.
  always_ff @(posedge clk) begin
    if (!reset_n) irq_in_q <= '0;
    else          irq_in_q <= irq_in;
  end
`endif

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .vec (pending_q),
    .any (enc_any),
    .idx (enc_idx)
  );

  // Mask register and pending latch; a set in the ack cycle beats the clear.
  always_comb begin
    enable_d = mask_wr ? mask_wdata : enable_q;
`ifdef IRQCTL_EDGE_EN
    set_vec  = irq_in & ~irq_in_q & enable_q;
`else
    set_vec  = irq_in & enable_q;
`endif
    ack_take = (state_q == REQ) && irq_ack;
    clr_vec  = '0;
    if (ack_take) clr_vec = NUM_SRC'(1) << id_q;
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // Next state and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          id_d    = enc_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_take) state_d = SERVICE;
      end
      SERVICE: begin
        if (irq_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == REQ);
    busy_d = (state_d == SERVICE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      id_q      <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      id_q      <= id_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
    end
  end

  assign irq_enable  = enable_q;
  assign irq_pending = pending_q;
  assign irq_id      = id_q;
  assign irq_req     = req_q;
  assign irq_busy    = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: table of per-cycle vectors with hand-derived
// expectations, run through a scoreboard queue, plus hand sequences.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_wdata;
  logic [7:0] irq_enable;
  logic [7:0] irq_pending;
  logic       irq_req;
  logic [2:0] irq_id;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq_busy;

  always #5 clk = ~clk;

  irq_controller #(.NUM_SRC(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq_in      (irq_in),
    .mask_wr     (mask_wr),
    .mask_wdata  (mask_wdata),
    .irq_enable  (irq_enable),
    .irq_pending (irq_pending),
    .irq_req     (irq_req),
    .irq_id      (irq_id),
    .irq_ack     (irq_ack),
    .irq_eoi     (irq_eoi),
    .irq_busy    (irq_busy)
  );

  typedef struct {
    logic       rn;
    logic [7:0] in;
    logic       mw;
    logic [7:0] md;
    logic       ack;
    logic       eoi;
    logic       xreq;
    logic       xbusy;
    logic [2:0] xid;
    logic [7:0] xpend;
    logic [7:0] xen;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   row   = 0;

  function automatic vec_t mk(input logic rn, input logic [7:0] in, input logic mw,
                              input logic [7:0] md, input logic ack, input logic eoi,
                              input logic xreq, input logic xbusy, input logic [2:0] xid,
                              input logic [7:0] xpend, input logic [7:0] xen);
    vec_t v;
    v.rn = rn; v.in = in; v.mw = mw; v.md = md; v.ack = ack; v.eoi = eoi;
    v.xreq = xreq; v.xbusy = xbusy; v.xid = xid; v.xpend = xpend; v.xen = xen;
    return v;
  endfunction

  task automatic add(input logic rn, input logic [7:0] in, input logic mw,
                     input logic [7:0] md, input logic ack, input logic eoi,
                     input logic xreq, input logic xbusy, input logic [2:0] xid,
                     input logic [7:0] xpend, input logic [7:0] xen);
    tbl.push_back(mk(rn, in, mw, md, ack, eoi, xreq, xbusy, xid, xpend, xen));
  endtask

  task automatic chk(input string nm, input int r, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, r, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    vec_t x;
    reset_n    = v.rn;
    irq_in     = v.in;
    mask_wr    = v.mw;
    mask_wdata = v.md;
    irq_ack    = v.ack;
    irq_eoi    = v.eoi;
    sb.push_back(v);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("req",     row, 32'(irq_req),     32'(x.xreq));
    chk("busy",    row, 32'(irq_busy),    32'(x.xbusy));
    chk("id",      row, 32'(irq_id),      32'(x.xid));
    chk("pending", row, 32'(irq_pending), 32'(x.xpend));
    chk("enable",  row, 32'(irq_enable),  32'(x.xen));
    row++;
  endtask

  initial begin
    logic [7:0] rel_in;
    int         req_cycles;
`ifdef IRQCTL_EDGE_EN
    rel_in = 8'h00;
`else
    rel_in = 8'h10;
`endif
    //   rn in     mw md     ack eoi  req busy id pend   en
    // reset with a line up, then release
    for (int i = 0; i < 3; i++) add(0, 8'h10, 1, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    add(1, rel_in, 1, 8'hFF, 0, 0,  0, 0, 0, 8'h00, 8'hFF);
    add(1, 8'h10, 0, 8'h00, 0, 0,   0, 0, 0, 8'h10, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 0,   1, 0, 4, 8'h10, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 1, 0,   0, 1, 4, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 4, 8'h00, 8'hFF);
    // priority: two sources, lowest first
    add(1, 8'h24, 0, 8'h00, 0, 0,   0, 0, 4, 8'h24, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 0,   1, 0, 2, 8'h24, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 1, 0,   0, 1, 2, 8'h20, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 2, 8'h20, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 0,   1, 0, 5, 8'h20, 8'hFF);
    // freeze in REQ, stray eoi, ack+eoi together, stray ack in SERVICE
    add(1, 8'h01, 0, 8'h00, 0, 0,   1, 0, 5, 8'h21, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 0,   1, 0, 5, 8'h21, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 1,   1, 0, 5, 8'h21, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 1, 1,   0, 1, 5, 8'h01, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 1, 0,   0, 1, 5, 8'h01, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 5, 8'h01, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 0,   1, 0, 0, 8'h01, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 1, 0,   0, 1, 0, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 1, 0,   0, 0, 0, 8'h00, 8'hFF);
    // line 3 held high across the ack
    add(1, 8'h08, 0, 8'h00, 0, 0,   0, 0, 0, 8'h08, 8'hFF);
    add(1, 8'h08, 0, 8'h00, 0, 0,   1, 0, 3, 8'h08, 8'hFF);
`ifdef IRQCTL_EDGE_EN
    add(1, 8'h08, 0, 8'h00, 1, 0,   0, 1, 3, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 3, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 0,   0, 0, 3, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 1, 0,   0, 0, 3, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 3, 8'h00, 8'hFF);
`else
    add(1, 8'h08, 0, 8'h00, 1, 0,   0, 1, 3, 8'h08, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 3, 8'h08, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 0,   1, 0, 3, 8'h08, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 1, 0,   0, 1, 3, 8'h00, 8'hFF);
    add(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 3, 8'h00, 8'hFF);
`endif
    // masking: all lines up with everything disabled
    add(1, 8'h00, 1, 8'h00, 0, 0,   0, 0, 3, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) add(1, 8'hFF, 0, 8'h00, 0, 0, 0, 0, 3, 8'h00, 8'h00);
    add(1, 8'h00, 1, 8'h02, 0, 0,   0, 0, 3, 8'h00, 8'h02);
    add(1, 8'hFF, 0, 8'h00, 0, 0,   0, 0, 3, 8'h02, 8'h02);
    add(1, 8'h00, 0, 8'h00, 0, 0,   1, 0, 1, 8'h02, 8'h02);
    add(1, 8'h00, 1, 8'h00, 0, 0,   1, 0, 1, 8'h02, 8'h00);
    add(1, 8'h00, 0, 8'h00, 0, 0,   1, 0, 1, 8'h02, 8'h00);
    add(1, 8'h00, 0, 8'h00, 1, 0,   0, 1, 1, 8'h00, 8'h00);
    add(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 1, 8'h00, 8'h00);

    foreach (tbl[k]) step(tbl[k]);

    // reset while in SERVICE, then stray eoi/ack afterwards
    step(mk(1, 8'h00, 1, 8'hFF, 0, 0,  0, 0, 1, 8'h00, 8'hFF));
    step(mk(1, 8'h80, 0, 8'h00, 0, 0,  0, 0, 1, 8'h80, 8'hFF));
    step(mk(1, 8'h00, 0, 8'h00, 0, 0,  1, 0, 7, 8'h80, 8'hFF));
    step(mk(1, 8'h00, 0, 8'h00, 1, 0,  0, 1, 7, 8'h00, 8'hFF));
    step(mk(0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 8'h00));
    step(mk(1, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 8'h00));
    step(mk(1, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00, 8'h00));

`ifdef IRQCTL_EDGE_EN
    // line 6 held high for 20 cycles yields a single request
    step(mk(1, 8'h00, 1, 8'hFF, 0, 0,  0, 0, 0, 8'h00, 8'hFF));
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      case (i)
        0:       step(mk(1, 8'h40, 0, 8'h00, 0, 0, 0, 0, 0, 8'h40, 8'hFF));
        1:       step(mk(1, 8'h40, 0, 8'h00, 0, 0, 1, 0, 6, 8'h40, 8'hFF));
        2:       step(mk(1, 8'h40, 0, 8'h00, 1, 0, 0, 1, 6, 8'h00, 8'hFF));
        3:       step(mk(1, 8'h40, 0, 8'h00, 0, 1, 0, 0, 6, 8'h00, 8'hFF));
        default: step(mk(1, 8'h40, 0, 8'h00, 0, 0, 0, 0, 6, 8'h00, 8'hFF));
      endcase
      if (irq_req) req_cycles++;
    end
    chk("edge_req_count", row, 32'(req_cycles), 32'd1);
`else
    req_cycles = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
